// File: rtl/ram_stream_reader.sv
// Drains a contiguous RAM address range and serializes each word onto a
// narrow valid/ready stream, least-significant slice first.
module ram_stream_reader #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int OUT_WIDTH     = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   word_count,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  input  logic [DATA_WIDTH-1:0]    ram_data,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int BEATS  = DATA_WIDTH / OUT_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0]        BEAT_ZERO = {BEAT_W{1'b0}};
  localparam logic [BEAT_W-1:0]        BEAT_ONE  = {{(BEAT_W-1){1'b0}}, 1'b1};
  localparam logic [BEAT_W-1:0]        LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDRESS_WIDTH:0]   CNT_ZERO  = {(ADDRESS_WIDTH+1){1'b0}};
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE   = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = {ADDRESS_WIDTH{1'b0}};
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0]    WORD_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [OUT_WIDTH-1:0]     OUT_ZERO  = {OUT_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_r;
  logic [ADDRESS_WIDTH:0]  remaining_r;
  logic [BEAT_W-1:0]       beat_r;
  logic [DATA_WIDTH-1:0]   word_r;
  logic [DATA_WIDTH-1:0]   word_shift_s;
  logic                    last_beat_s;
  logic                    more_words_s;

  // Word register keeps only the unsent slices, so the next beat is always its low slice.
  always_comb begin
    word_shift_s = word_r >> OUT_WIDTH;
    last_beat_s  = (beat_r == LAST_BEAT);
    more_words_s = (remaining_r != CNT_ONE);
  end

  // Transfer sequencer with registered stream, RAM address and status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      remaining_r <= CNT_ZERO;
      beat_r      <= BEAT_ZERO;
      word_r      <= WORD_ZERO;
      ram_address <= ADDR_ZERO;
      out_data    <= OUT_ZERO;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done      <= 1'b0;
          out_valid <= 1'b0;
          if (start) begin
            if (word_count != CNT_ZERO) begin
              ram_address <= base_addr;
              remaining_r <= word_count;
              busy        <= 1'b1;
              state_r     <= FETCH;
            end else begin
              state_r <= DONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        FETCH: begin
          word_r    <= ram_data;
          out_data  <= ram_data[OUT_WIDTH-1:0];
          out_valid <= 1'b1;
          beat_r    <= BEAT_ZERO;
          state_r   <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (!last_beat_s) begin
              beat_r   <= beat_r + BEAT_ONE;
              word_r   <= word_shift_s;
              out_data <= word_shift_s[OUT_WIDTH-1:0];
            end else if (more_words_s) begin
              remaining_r <= remaining_r - CNT_ONE;
              ram_address <= ram_address + ADDR_ONE;
              out_valid   <= 1'b0;
              state_r     <= FETCH;
            end else begin
              remaining_r <= CNT_ZERO;
              out_valid   <= 1'b0;
              busy        <= 1'b0;
              state_r     <= DONE;
            end
          end else begin
            state_r <= SEND;
          end
        end
        DONE: begin
          done    <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized self-checking bench for ram_stream_reader; expected beats come
// from slicing a behavioural RAM array over the requested address range.
module tb_ram_stream_reader;

  localparam int AW    = 13;
  localparam int DW    = 64;
  localparam int OW    = 32;
  localparam int BEATS = DW / OW;
  localparam int DEPTH = 1 << AW;

  logic          CLK;
  logic          RST;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];
  int tests_run;
  int fails;

  assign ram_data = mem[ram_address];

  ram_stream_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .base_addr(base_addr),
    .word_count(word_count), .ram_address(ram_address), .ram_data(ram_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // mode: 0 = ready always high, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random ready
  task automatic run_transfer(input logic [AW-1:0] base, input logic [AW:0] cnt,
                              input int mode, input bit inject, input string name);
    logic [OW-1:0] exp_q[$];
    logic [DW-1:0] w;
    logic [AW-1:0] a;
    logic [OW-1:0] held;
    logic [OW-1:0] e;
    bit            held_v;
    bit            pat [6];
    int            cyc;
    int            done_cyc;
    int            first_valid;
    int            limit;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_q = {};
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + AW'(i);
      w = mem[a];
      for (int b = 0; b < BEATS; b++) exp_q.push_back(w[b*OW +: OW]);
    end
    limit = int'(cnt) * 40 + 50;
    @(posedge CLK); #1;
    start = 1'b1; base_addr = base; word_count = cnt; out_ready = 1'b1;
    cyc = 0; done_cyc = -1; first_valid = -1; held_v = 1'b0; held = '0;
    while (done_cyc < 0 && cyc < limit) begin
      @(posedge CLK); #1;
      cyc++;
      start      = inject && (cyc == 3);
      base_addr  = inject ? ~base : base;
      word_count = inject ? (AW+1)'($urandom) : cnt;
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = pat[(cyc - 1) % 6];
      else                out_ready = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (held_v) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          fails++;
          $display("FAIL %s hold cyc %0d: valid=%b data=%h, required valid=1 data=%h",
                   name, cyc, out_valid, out_data, held);
        end
      end
      if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL %s extra beat cyc %0d: got %h, required no beat", name, cyc, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            fails++;
            $display("FAIL %s beat cyc %0d: got %h, required %h", name, cyc, out_data, e);
          end
        end
      end
      held_v = (out_valid === 1'b1) && (out_ready === 1'b0);
      held   = out_data;
      if (mode == 0 && cnt != '0 && ((cyc - 1) % 3) == 0 && ((cyc - 1) / 3) < int'(cnt)) begin
        a = base + AW'((cyc - 1) / 3);
        tests_run++;
        if (ram_address !== a) begin
          fails++;
          $display("FAIL %s ram_address cyc %0d: got %h, required %h", name, cyc, ram_address, a);
        end
      end
      if (cyc == 1) begin
        tests_run++;
        if (busy !== (cnt != '0)) begin
          fails++;
          $display("FAIL %s busy after start: got %b, required %b", name, busy, cnt != '0);
        end
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
          fails++;
          $display("FAIL %s done cycle: busy=%b valid=%b, required 0 0", name, busy, out_valid);
        end
      end
    end
    start = 1'b0;
    tests_run++;
    if (done_cyc < 0) begin
      fails++;
      $display("FAIL %s timeout: no done within %0d cycles", name, limit);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s missing beats: %0d left, required 0", name, exp_q.size());
    end
    if (mode == 0) begin
      tests_run++;
      if (done_cyc != int'(cnt) * (BEATS + 1) + 2) begin
        fails++;
        $display("FAIL %s done latency: got %0d, required %0d", name, done_cyc,
                 int'(cnt) * (BEATS + 1) + 2);
      end
    end
    tests_run++;
    if (first_valid != ((cnt != '0) ? 2 : -1)) begin
      fails++;
      $display("FAIL %s first valid cycle: got %0d, required %0d", name, first_valid,
               (cnt != '0) ? 2 : -1);
    end
    for (int i = 0; i < (inject ? 10 : 2); i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      tests_run++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL %s idle after done: done=%b valid=%b, required 0 0", name, done, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; word_count = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if (ram_address !== '0 || out_data !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset: addr=%h data=%h valid=%b busy=%b done=%b, required all 0",
               ram_address, out_data, out_valid, busy, done);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_basic();
    mem[5] = 64'h1111_2222_3333_4444;
    mem[6] = 64'hAAAA_BBBB_CCCC_DDDD;
    run_transfer(13'd5, 14'd2, 0, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    run_transfer(13'd5, 14'd2, 1, 1'b0, "backpressure");
    run_transfer(13'($urandom), 14'($urandom_range(1, 12)), 2, 1'b0, "random_ready");
  endtask

  task automatic test_zero_count();
    run_transfer(13'($urandom), 14'd0, 0, 1'b0, "zero_count");
  endtask

  task automatic test_wrap();
    mem[13'h1FFF] = 64'h1;
    mem[13'h0000] = 64'h2;
    run_transfer(13'h1FFF, 14'd2, 0, 1'b0, "wrap");
  endtask

  task automatic test_ignored_start();
    run_transfer(13'($urandom), 14'd2, 0, 1'b1, "ignored_start");
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++)
      run_transfer(13'($urandom), 14'($urandom_range(1, 16)), t % 3, 1'b0, "random");
  endtask

  task automatic test_full_ram();
    run_transfer(13'($urandom), 14'd8192, 0, 1'b0, "full_ram");
  endtask

  task automatic test_reset_mid_op();
    logic [AW-1:0] base;
    logic [OW-1:0] e;
    logic [DW-1:0] w;
    base = 13'($urandom);
    w = mem[base];
    e = w[OW-1:0];
    @(posedge CLK); #1;
    start = 1'b1; base_addr = base; word_count = 14'd3; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      if (cyc == 6) RST = 1'b1;
      @(negedge CLK);
      if (cyc == 2) begin
        tests_run++;
        if (out_data !== e) begin
          fails++;
          $display("FAIL reset_mid first beat: got %h, required %h", out_data, e);
        end
      end
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ram_address !== '0) begin
      fails++;
      $display("FAIL reset_mid abort: valid=%b busy=%b done=%b addr=%h, required 0 0 0 0",
               out_valid, busy, done, ram_address);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      tests_run++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid quiet: done=%b valid=%b, required 0 0", done, out_valid);
      end
    end
    run_transfer(13'($urandom), 14'd1, 0, 1'b0, "after_reset");
  endtask

  initial begin
    tests_run = 0;
    fails = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_wrap();
    test_ignored_start();
    test_random();
    test_reset_mid_op();
    test_full_ram();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
